ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED followed by an LED mask for Caps Lock or language-mode indication.
- It is the opposite direction of the keyboard receive path, which feeds the scancode-to-character ROM.
- Drives the open-drain PS/2 clock and data lines through output-enable pins. Reports completion and ACK/NACK status.
- While tx_idle=0 the receive path must ignore line activity.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 45 ++++
 rtl/ps2_host_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame constants, parity helper
// and common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam int DATA_BITS = 8;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-flop synchronizer, FILTER_LEN-sample glitch filter
// and a one-cycle fall tick on the filtered level. Shared with the receive path.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall_tick
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_shift;
    logic                  r_level;
    logic                  r_fall;
    logic                  w_all1;
    logic                  w_all0;

    assign w_all1 = &r_shift;
    assign w_all0 = ~|r_shift;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= '1;
            r_shift <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_pad};
            r_shift <= {r_shift[FILTER_LEN-2:0], r_sync[1]};
            if (w_all1) begin
                r_level <= 1'b1;
            end else if (w_all0) begin
                r_level <= 1'b0;
            end
            // Tick coincides with the cycle the filtered level first reads 0.
            r_fall  <= r_level & w_all0;
        end
    end

    assign o_level     = r_level;
    assign o_fall_tick = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data through
// output enables, with device-clock watchdog and ACK/NACK status.
//   state     | meaning
//   IDLE      | lines released, waiting for wr_ps2
//   RTS       | host holds clock low for INHIBIT_CYCLES
//   START     | data held low (start bit), waiting for first device fall
//   DATA      | presenting data bits then parity, one per device fall
//   STOP      | data released (stop bit), ACK sampled on fall 11
//   WAIT_IDLE | waiting for device to release both lines
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_ps2,
    input  logic [7:0] i_din,
    input  logic       i_ps2c_in,
    input  logic       i_ps2d_in,
    output logic       o_ps2c_oe,
    output logic       o_ps2d_oe,
    output logic       o_tx_idle,
    output logic       o_tx_done_tick,
    output logic       o_tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_tx_state_t   r_state;
    logic [8:0]      r_sreg;
    logic [3:0]      r_n;
    logic [CNT_W-1:0] r_cnt;
    logic            r_err;
    logic            r_done;
    logic            r_c_oe;
    logic            r_d_oe;

    ps2_tx_state_t   w_state_next;
    logic [8:0]      w_sreg_next;
    logic [3:0]      w_n_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic            w_err_next;
    logic            w_done_next;
    logic            w_c_oe_next;
    logic            w_d_oe_next;

    logic            w_c_level;
    logic            w_d_level;
    logic            w_fall;
    logic            w_d_fall_unused;
    logic            w_active;
    logic            w_timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pad       (i_ps2c_in),
        .o_level     (w_c_level),
        .o_fall_tick (w_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pad       (i_ps2d_in),
        .o_level     (w_d_level),
        .o_fall_tick (w_d_fall_unused)
    );

    assign w_active  = (r_state == START) || (r_state == DATA) ||
                       (r_state == STOP)  || (r_state == WAIT_IDLE);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        w_sreg_next  = r_sreg;
        w_n_next     = r_n;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_done_next  = 1'b0;

        // Watchdog first; state-specific progress below overrides it, so a
        // fall tick coinciding with the timeout keeps the frame alive.
        if (w_active) begin
            if (w_fall) begin
                w_cnt_next = '0;
            end else if (w_timeout) begin
                w_state_next = IDLE;
                w_err_next   = 1'b1;
                w_done_next  = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            IDLE: begin
                if (i_wr_ps2) begin
                    w_sreg_next  = {odd_parity(i_din), i_din};
                    w_n_next     = '0;
                    w_cnt_next   = '0;
                    w_err_next   = 1'b0;
                    w_state_next = RTS;
                end
            end
            RTS: begin
                if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = START;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            START: begin
                if (w_fall) begin
                    w_n_next     = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_fall) begin
                    if (r_n == 4'(DATA_BITS)) begin
                        w_state_next = STOP;
                    end else begin
                        w_sreg_next = {1'b0, r_sreg[8:1]};
                        w_n_next    = r_n + 4'd1;
                    end
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_err_next   = w_d_level;
                    w_state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_c_level && w_d_level) begin
                    w_err_next   = r_err;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Pad enables are registered from the next state so the pins never glitch.
        w_c_oe_next = (w_state_next == RTS);
        w_d_oe_next = (w_state_next == START) ||
                      ((w_state_next == DATA) && !w_sreg_next[0]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sreg  <= w_sreg_next;
            r_n     <= w_n_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
            r_done  <= w_done_next;
            r_c_oe  <= w_c_oe_next;
            r_d_oe  <= w_d_oe_next;
        end
    end

    assign o_ps2c_oe      = r_c_oe;
    assign o_ps2d_oe      = r_d_oe;
    assign o_tx_idle      = (r_state == IDLE);
    assign o_tx_done_tick = r_done;
    assign o_tx_err       = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed plus randomized bench for ps2_host_tx with a behavioural PS/2 device
// that clocks frames, captures the host's bits and answers ACK or NACK.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 500;
    localparam int FLT  = 4;
    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       glitch_c = 1'b0;
    logic       c_oe, d_oe, idle, done, err;
    logic       ps2c, ps2d;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    assign ps2c = ~(c_oe | dev_c_low | glitch_c);
    assign ps2d = ~(d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wr_ps2       (wr),
        .i_din          (din),
        .i_ps2c_in      (ps2c),
        .i_ps2d_in      (ps2d),
        .o_ps2c_oe      (c_oe),
        .o_ps2d_oe      (d_oe),
        .o_tx_idle      (idle),
        .o_tx_done_tick (done),
        .o_tx_err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels in transmission order: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        int rts;
        @(negedge clk);
        wr = 1'b1;
        din = d;
        @(negedge clk);
        wr = 1'b0;
        chk("accept_idle", 32'(idle), 0);
        chk("accept_err_clr", 32'(err), 0);
        rts = 0;
        while (c_oe === 1'b1 && rts < 1000) begin
            rts++;
            @(negedge clk);
        end
        chk("rts_len", 32'(rts), INH);
        chk("start_d_oe", 32'(d_oe), 1);
        chk("start_c_rel", 32'(c_oe), 0);
    endtask

    task automatic dev_frame(input bit ack, input bit disturb, output logic [10:0] got);
        got = '0;
        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk);
                if (i == 45) got[k] = ps2d;
                if (k == 10 && i == 50 && ack) dev_d_low = 1'b1;
                if (disturb && k == 4) begin
                    if (i == 20) glitch_c = 1'b1;
                    if (i == 22) glitch_c = 1'b0;
                    if (i == 30) begin
                        wr = 1'b1;
                        din = 8'h5A;
                    end
                    if (i == 31) wr = 1'b0;
                end
            end
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
        end
        dev_d_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input bit disturb);
        logic [10:0] got;
        int t;
        int base;
        start_tx(d);
        base = done_cnt;
        dev_frame(ack, disturb, got);
        if (disturb) chk("busy_after_disturb", 32'(idle), 0);
        chk("frame_bits", 32'(got), 32'(frame_of(d)));
        t = 0;
        while (done !== 1'b1 && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("done_tick", 32'(done), 1);
        chk("ack_status", 32'(err), ack ? 0 : 1);
        chk("idle_after", 32'(idle), 1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("done_count", 32'(done_cnt - base), 1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int t;
        int base;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_c_oe", 32'(c_oe), 0);
        chk("rst_d_oe", 32'(d_oe), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send(8'hED, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'hEE, 1'b0, 1'b0);

        // Device never clocks: watchdog aborts after TMO cycles in START.
        start_tx(8'hFF);
        t = 0;
        while (d_oe === 1'b1 && t < 2000) begin
            t++;
            @(negedge clk);
        end
        chk("timeout_len", 32'(t), TMO);
        chk("timeout_done", 32'(done), 1);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_idle", 32'(idle), 1);
        chk("timeout_c_oe", 32'(c_oe), 0);
        chk("timeout_d_oe", 32'(d_oe), 0);
        repeat (20) @(negedge clk);

        // Reset shortly after the fifth device fall.
        start_tx(8'hED);
        base = done_cnt;
        for (int k = 0; k < 5; k++) begin
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b1;
            if (k < 4) begin
                repeat (HALF) @(negedge clk);
                dev_c_low = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        chk("midframe_busy", 32'(idle), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_c_oe", 32'(c_oe), 0);
        chk("mrst_d_oe", 32'(d_oe), 0);
        chk("mrst_idle", 32'(idle), 1);
        chk("mrst_done", 32'(done), 0);
        reset = 1'b0;
        dev_c_low = 1'b0;
        repeat (50) @(negedge clk);
        chk("mrst_no_done", 32'(done_cnt - base), 0);
        send(8'hED, 1'b1, 1'b0);

        // Clock glitch and a second request in the middle of the frame.
        send(8'hA5, 1'b1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
